// File: rtl/pulse_gen_mc.sv
// Multi-channel pulse-train generator producing SER_W-bit words per clk_div cycle.
// Each lane runs its own IDLE/HIGH/GAP/DONE sequencer; a shared start aligns all enabled lanes.
module pulse_gen_mc #(
  parameter int CH           = 4,
  parameter int SER_W        = 8,
  parameter int WIDTH_W      = 12,
  parameter int PNUM_W       = 11,
  parameter int GAP_W        = 16,
  parameter int TICKS_PER_US = 125
) (
  input  logic                  clk_div,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CH-1:0]         ch_en_i,
  input  logic [CH*WIDTH_W-1:0] width_i,
  input  logic [CH*PNUM_W-1:0]  pnum_i,
  input  logic [CH*GAP_W-1:0]   gap_us_i,
  input  logic [CH-1:0]         inv_i,
  output logic [CH*SER_W-1:0]   data_o,
  output logic [CH-1:0]         trig_o,
  output logic [CH-1:0]         busy_o,
  output logic [CH-1:0]         done_o
);

  localparam int LOG_S  = $clog2(SER_W);
  localparam int WC_W   = WIDTH_W - LOG_S;
  localparam int TICK_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_GAP,
    ST_DONE
  } state_t;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    state_t              r_state, w_state;
    logic [WC_W-1:0]     r_word, w_word;
    logic [TICK_W-1:0]   r_tick, w_tick;
    logic [GAP_W-1:0]    r_us, w_us;
    logic [PNUM_W-1:0]   r_pcnt, w_pcnt;
    logic [WIDTH_W-1:0]  r_width, w_width;
    logic [PNUM_W-1:0]   r_pnum, w_pnum;
    logic [GAP_W-1:0]    r_gap, w_gap;
    logic                r_inv, w_inv;
    logic [SER_W-1:0]    r_data, w_data;
    logic                r_trig, w_trig;
    logic                r_busy, w_busy;
    logic                r_done, w_done;

    logic [WIDTH_W-1:0]  w_cfg_width;
    logic [WC_W-1:0]     w_nf;
    logic [LOG_S-1:0]    w_rem;
    logic [SER_W-1:0]    w_rem_mask;
    logic [WC_W-1:0]     w_word_nx;
    logic                w_last_hi;
    logic                w_gap_last;
    logic [PNUM_W-1:0]   w_pnext;
    logic [SER_W-1:0]    w_pat;
    logic                w_begin;
    logic                w_end;

    // A fresh start builds its first word from the live inputs; later pulses use the latched width.
    assign w_cfg_width = (r_state == ST_IDLE) ? width_i[gi*WIDTH_W +: WIDTH_W] : r_width;
    assign w_nf        = w_cfg_width[WIDTH_W-1:LOG_S];
    assign w_rem       = w_cfg_width[LOG_S-1:0];
    assign w_rem_mask  = (SER_W'(1) << w_rem) - SER_W'(1);
    assign w_word_nx   = r_word + WC_W'(1);
    assign w_last_hi   = (w_rem != '0) ? (r_word == w_nf) : (r_word == w_nf - WC_W'(1));
    assign w_gap_last  = (r_gap == '0) ||
                         ((r_tick == TICK_W'(TICKS_PER_US - 1)) && (r_us == r_gap - GAP_W'(1)));
    assign w_pnext     = r_pcnt + PNUM_W'(1);

    always_comb begin
      w_state = r_state;
      w_word  = r_word;
      w_tick  = r_tick;
      w_us    = r_us;
      w_pcnt  = r_pcnt;
      w_width = r_width;
      w_pnum  = r_pnum;
      w_gap   = r_gap;
      w_inv   = r_inv;
      w_pat   = '0;
      w_trig  = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      w_begin = 1'b0;
      w_end   = 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start_i && ch_en_i[gi] && !abort_i) begin
            w_width = width_i[gi*WIDTH_W +: WIDTH_W];
            w_pnum  = pnum_i[gi*PNUM_W +: PNUM_W];
            w_gap   = gap_us_i[gi*GAP_W +: GAP_W];
            w_inv   = inv_i[gi];
            w_pcnt  = '0;
            w_begin = 1'b1;
          end
        end
        ST_HIGH: begin
          if (!w_last_hi) begin
            w_word = w_word_nx;
            w_pat  = (w_word_nx < w_nf) ? '1 : w_rem_mask;
            w_busy = 1'b1;
          end else if (r_gap != '0) begin
            w_state = ST_GAP;
            w_tick  = '0;
            w_us    = '0;
            w_busy  = 1'b1;
          end else begin
            w_end = 1'b1;
          end
        end
        ST_GAP: begin
          if (w_gap_last) begin
            w_end = 1'b1;
          end else begin
            w_busy = 1'b1;
            if (r_tick == TICK_W'(TICKS_PER_US - 1)) begin
              w_tick = '0;
              w_us   = r_us + GAP_W'(1);
            end else begin
              w_tick = r_tick + TICK_W'(1);
            end
          end
        end
        ST_DONE: begin
          w_state = ST_IDLE;
        end
        default: begin
          w_state = ST_IDLE;
        end
      endcase

      // Continuous trains (pnum = 0) hold the pulse counter and never finish on their own.
      if (w_end) begin
        if ((r_pnum != '0) && (w_pnext == r_pnum)) begin
          w_state = ST_DONE;
          w_done  = 1'b1;
        end else begin
          if (r_pnum != '0) begin
            w_pcnt = w_pnext;
          end
          w_begin = 1'b1;
        end
      end

      if (w_begin) begin
        w_trig = 1'b1;
        w_busy = 1'b1;
        if (w_cfg_width != '0) begin
          w_state = ST_HIGH;
          w_word  = '0;
          w_pat   = (w_nf != '0) ? '1 : w_rem_mask;
        end else begin
          w_state = ST_GAP;
          w_tick  = '0;
          w_us    = '0;
        end
      end

      if (abort_i && (r_state != ST_IDLE)) begin
        w_state = ST_IDLE;
        w_pat   = '0;
        w_trig  = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
      end

      w_data = w_pat ^ {SER_W{w_inv}};
    end

    always_ff @(posedge clk_div) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_word  <= '0;
        r_tick  <= '0;
        r_us    <= '0;
        r_pcnt  <= '0;
        r_width <= '0;
        r_pnum  <= '0;
        r_gap   <= '0;
        r_inv   <= 1'b0;
        r_data  <= '0;
        r_trig  <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_state <= w_state;
        r_word  <= w_word;
        r_tick  <= w_tick;
        r_us    <= w_us;
        r_pcnt  <= w_pcnt;
        r_width <= w_width;
        r_pnum  <= w_pnum;
        r_gap   <= w_gap;
        r_inv   <= w_inv;
        r_data  <= w_data;
        r_trig  <= w_trig;
        r_busy  <= w_busy;
        r_done  <= w_done;
      end
    end

    assign data_o[gi*SER_W +: SER_W] = r_data;
    assign trig_o[gi]                = r_trig;
    assign busy_o[gi]                = r_busy;
    assign done_o[gi]                = r_done;
  end

endmodule

// File: tb/tb_pulse_gen_mc.sv
// Bench for pulse_gen_mc: directed scenarios followed by randomized traffic, all outputs
// compared every cycle against a word-list model of each channel's pulse train.
module tb_pulse_gen_mc;
  localparam int CH = 4, SER_W = 8, WIDTH_W = 12, PNUM_W = 11, GAP_W = 16, TPU = 125;

  logic                  clk_div = 1'b0;
  logic                  rst, start_i, abort_i;
  logic [CH-1:0]         ch_en_i, inv_i;
  logic [CH*WIDTH_W-1:0] width_i;
  logic [CH*PNUM_W-1:0]  pnum_i;
  logic [CH*GAP_W-1:0]   gap_us_i;
  logic [CH*SER_W-1:0]   data_o;
  logic [CH-1:0]         trig_o, busy_o, done_o;

  pulse_gen_mc #(
    .CH(CH), .SER_W(SER_W), .WIDTH_W(WIDTH_W), .PNUM_W(PNUM_W),
    .GAP_W(GAP_W), .TICKS_PER_US(TPU)
  ) dut (
    .clk_div(clk_div), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .ch_en_i(ch_en_i), .width_i(width_i), .pnum_i(pnum_i), .gap_us_i(gap_us_i),
    .inv_i(inv_i), .data_o(data_o), .trig_o(trig_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_div = ~clk_div;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  // Model: each started channel owns a list of the exact words it will emit.
  typedef struct packed {
    logic [SER_W-1:0] d;
    logic             t;
    logic             b;
    logic             dn;
  } item_t;

  item_t mq[CH][$];
  item_t m_cur[CH];
  logic  m_act[CH];
  logic  m_inv[CH];
  int    m_w[CH], m_p[CH], m_g[CH];

  logic [CH*SER_W-1:0] exp_d;
  logic [CH-1:0]       exp_t, exp_b, exp_dn;

  function automatic item_t idle_item(int c);
    item_t it;
    it.d  = {SER_W{m_inv[c]}};
    it.t  = 1'b0;
    it.b  = 1'b0;
    it.dn = 1'b0;
    return it;
  endfunction

  function automatic void push_pulse(int c);
    item_t it;
    int hw;
    int bits;
    logic first;
    hw    = (m_w[c] + SER_W - 1) / SER_W;
    first = 1'b1;
    for (int k = 0; k < hw; k++) begin
      bits  = (m_w[c] - k*SER_W >= SER_W) ? SER_W : (m_w[c] - k*SER_W);
      it.d  = SER_W'((1 << bits) - 1) ^ {SER_W{m_inv[c]}};
      it.t  = first;
      it.b  = 1'b1;
      it.dn = 1'b0;
      mq[c].push_back(it);
      first = 1'b0;
    end
    for (int k = 0; k < m_g[c]*TPU; k++) begin
      it.d  = {SER_W{m_inv[c]}};
      it.t  = first;
      it.b  = 1'b1;
      it.dn = 1'b0;
      mq[c].push_back(it);
      first = 1'b0;
    end
  endfunction

  function automatic void push_train(int c);
    item_t it;
    if (m_p[c] == 0) begin
      push_pulse(c);
    end else begin
      for (int p = 0; p < m_p[c]; p++) push_pulse(c);
      it    = idle_item(c);
      it.dn = 1'b1;
      mq[c].push_back(it);
    end
  endfunction

  always @(posedge clk_div) begin
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        mq[c].delete();
        m_act[c] = 1'b0;
        m_inv[c] = 1'b0;
        m_cur[c] = '0;
      end else if (m_act[c]) begin
        if (abort_i || mq[c].size() == 0) begin
          mq[c].delete();
          m_act[c] = 1'b0;
          m_cur[c] = idle_item(c);
        end else begin
          m_cur[c] = mq[c].pop_front();
          if (m_p[c] == 0 && mq[c].size() == 0) push_pulse(c);
        end
      end else if (start_i && ch_en_i[c] && !abort_i) begin
        m_w[c]   = int'(width_i[c*WIDTH_W +: WIDTH_W]);
        m_p[c]   = int'(pnum_i[c*PNUM_W +: PNUM_W]);
        m_g[c]   = int'(gap_us_i[c*GAP_W +: GAP_W]);
        m_inv[c] = inv_i[c];
        push_train(c);
        m_cur[c] = mq[c].pop_front();
        m_act[c] = 1'b1;
        if (m_p[c] == 0 && mq[c].size() == 0) push_pulse(c);
      end else begin
        m_cur[c] = idle_item(c);
      end
      exp_d[c*SER_W +: SER_W] = m_cur[c].d;
      exp_t[c]  = m_cur[c].t;
      exp_b[c]  = m_cur[c].b;
      exp_dn[c] = m_cur[c].dn;
    end
    #1;
    check_val("data", 64'(data_o), 64'(exp_d));
    check_val("trig", 64'(trig_o), 64'(exp_t));
    check_val("busy", 64'(busy_o), 64'(exp_b));
    check_val("done", 64'(done_o), 64'(exp_dn));
  end

  task automatic set_ch(input int c, input int w, input int p, input int g, input logic iv);
    width_i[c*WIDTH_W +: WIDTH_W] = WIDTH_W'(w);
    pnum_i[c*PNUM_W +: PNUM_W]    = PNUM_W'(p);
    gap_us_i[c*GAP_W +: GAP_W]    = GAP_W'(g);
    inv_i[c]                      = iv;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_div);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    wait_cyc(1);
    start_i = 1'b0;
  endtask

  task automatic do_abort();
    abort_i = 1'b1;
    wait_cyc(1);
    abort_i = 1'b0;
  endtask

  initial begin
    int w, g;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    ch_en_i = '0; inv_i = '0; width_i = '0; pnum_i = '0; gap_us_i = '0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);

    // Single train; inputs are scrambled right after start to prove they are latched.
    set_ch(0, 19, 2, 1, 1'b0);
    ch_en_i = 4'b0001;
    do_start();
    set_ch(0, 5, 7, 3, 1'b1);
    wait_cyc(265);

    set_ch(0, 3, 1, 0, 1'b1);
    do_start();
    wait_cyc(5);

    // Multi-channel alignment with channel 2 left disabled.
    set_ch(0, 5, 1, 0, 1'b0);
    set_ch(1, 13, 1, 1, 1'b0);
    set_ch(2, 9, 1, 0, 1'b0);
    set_ch(3, 24, 2, 0, 1'b1);
    ch_en_i = 4'b1011;
    do_start();
    wait_cyc(140);

    // Continuous mode, a start while busy, then abort.
    set_ch(0, 8, 0, 0, 1'b0);
    ch_en_i = 4'b0001;
    do_start();
    wait_cyc(20);
    set_ch(0, 2, 1, 0, 1'b1);
    do_start();
    wait_cyc(28);
    do_abort();
    wait_cyc(5);

    set_ch(0, 0, 3, 1, 1'b0);
    do_start();
    wait_cyc(380);

    // Start together with abort on an idle channel.
    set_ch(0, 8, 1, 0, 1'b0);
    start_i = 1'b1; abort_i = 1'b1;
    wait_cyc(1);
    start_i = 1'b0; abort_i = 1'b0;
    wait_cyc(4);

    // Reset mid-GAP, then a fresh start with new settings.
    set_ch(0, 8, 2, 2, 1'b0);
    do_start();
    wait_cyc(130);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    set_ch(0, 11, 1, 0, 1'b1);
    do_start();
    wait_cyc(10);

    // Randomized traffic: settings change every cycle, strobes are sparse.
    for (int cyc = 0; cyc < 6000; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        w = int'($urandom_range(0, 40));
        g = int'($urandom_range(0, 2));
        if (w == 0 && g == 0) g = 1;
        set_ch(c, w, int'($urandom_range(0, 3)), g, 1'($urandom % 2));
      end
      ch_en_i = CH'($urandom);
      start_i = ($urandom % 40) == 0;
      abort_i = ($urandom % 300) == 0;
      rst     = ($urandom % 2000) == 0;
      wait_cyc(1);
    end
    start_i = 1'b0; abort_i = 1'b0; rst = 1'b0;
    wait_cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
